upstream_writeback: RTL



---
 rtl/upstream_writeback_if.sv | 40 ++++
 rtl/upstream_writeback.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/upstream_writeback_if.sv
// upstream_writeback_if
//   Bundles the eviction push port and the downstream write port of the
//   write-back issuer.
//
//   Push side: an eviction transfers on a rising clk edge where wr_valid and
//   wr_ready are both high. wr_valid may rise without waiting for wr_ready;
//   wr_ready depends only on FIFO occupancy, never on wr_valid.
//   Downstream side: req stays high until ack is seen on a rising edge.
//   mem_addr/mem_data are valid while mem_we is high. memwr is a single-cycle
//   completion pulse.
//
//   modport master : the issuer (upstream_writeback)
//   modport slave  : eviction source / downstream processor / testbench
interface upstream_writeback_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              req;
  logic              ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              memwr;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  wr_valid, wr_addr, wr_data, ack,
    output wr_ready, req, mem_addr, mem_data, mem_we, memwr, busy, timeout_err
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, ack,
    input  wr_ready, req, mem_addr, mem_data, mem_we, memwr, busy, timeout_err
  );
endinterface

// File: rtl/upstream_writeback.sv
// upstream_writeback
//   Write-back issuer. Cache evictions (address + data) are queued in a small
//   circular FIFO. For each entry, the issuer raises req and waits for ack.
//   It then holds mem_we for WRITE_CYCLES cycles with the head entry on
//   mem_addr/mem_data. Finally it pulses memwr for one cycle and pops the
//   entry.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   bus         : upstream_writeback_if.master. It carries the push port
//                 (wr_valid/wr_addr/wr_data/wr_ready) and the downstream
//                 port (req/ack/mem_addr/mem_data/mem_we/memwr).
//                 It also carries the status outputs busy and timeout_err.
//   dbg_state   : current FSM state (0 IDLE, 1 REQ, 2 WRITE, 3 DONE)
//   dbg_count   : FIFO occupancy
//
// Configuration
//   UPSTREAM_WB_ACK_TIMEOUT_EN : when defined, an entry waiting in REQ for
//   ACK_TIMEOUT cycles without ack is dropped and timeout_err is set (sticky).
//   When undefined, REQ waits forever and timeout_err is tied low.
module upstream_writeback #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int WRITE_CYCLES = 2,
  parameter int ACK_TIMEOUT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  upstream_writeback_if.master   bus,
  output logic [1:0]             dbg_state,
  output logic [$clog2(DEPTH):0] dbg_count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int WCW = $clog2(WRITE_CYCLES + 1);
  localparam logic [PW:0]    FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              req_q, mem_we_q, memwr_q;
  logic [WCW-1:0]    wcnt;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [PW:0]       count;

  logic              push, pop;

`ifdef UPSTREAM_WB_ACK_TIMEOUT_EN
  localparam int TCW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(ACK_TIMEOUT - 1);
  logic [TCW-1:0] tcnt;
  logic           timeout_q;
  logic           timeout_fire;

  // ack on the expiry edge takes priority, so expiry requires ack low.
  assign timeout_fire = (state == S_REQ) && !bus.ack && (tcnt == TO_LAST);
  assign bus.timeout_err = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg      = (ACK_TIMEOUT > 0);
  assign bus.timeout_err = 1'b0;
`endif

  // wr_ready is a pure function of occupancy. A pop in the same cycle does
  // not open a slot for a push while full.
  assign bus.wr_ready = (count < FULL_CNT);
  assign push         = bus.wr_valid && bus.wr_ready;

  always_comb begin
    pop = (state == S_DONE);
`ifdef UPSTREAM_WB_ACK_TIMEOUT_EN
    if (timeout_fire) pop = 1'b1;
`endif
  end

  assign bus.mem_addr = addr_mem[rptr];
  assign bus.mem_data = data_mem[rptr];
  assign bus.req      = req_q;
  assign bus.mem_we   = mem_we_q;
  assign bus.memwr    = memwr_q;
  assign bus.busy     = (state != S_IDLE) || (count != '0);
  assign dbg_state    = state;
  assign dbg_count    = count;

  // FIFO storage and pointers. Storage is cleared on reset so that the head
  // outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_mem[wptr] <= bus.wr_addr;
        data_mem[wptr] <= bus.wr_data;
        wptr           <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM. The Moore outputs are registered alongside the state so that
  // each output changes on the same edge as its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      req_q    <= 1'b0;
      mem_we_q <= 1'b0;
      memwr_q  <= 1'b0;
      wcnt     <= '0;
`ifdef UPSTREAM_WB_ACK_TIMEOUT_EN
      tcnt      <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            state <= S_REQ;
            req_q <= 1'b1;
`ifdef UPSTREAM_WB_ACK_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end
        end
        S_REQ: begin
          if (bus.ack) begin
            state    <= S_WRITE;
            req_q    <= 1'b0;
            mem_we_q <= 1'b1;
            wcnt     <= '0;
          end
`ifdef UPSTREAM_WB_ACK_TIMEOUT_EN
          else if (tcnt == TO_LAST) begin
            // Abandon the head entry. The FIFO pop happens through timeout_fire.
            state     <= S_IDLE;
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            tcnt <= tcnt + TCW'(1);
          end
`endif
        end
        S_WRITE: begin
          if (wcnt == WC_LAST) begin
            state    <= S_DONE;
            mem_we_q <= 1'b0;
            memwr_q  <= 1'b1;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          memwr_q <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          req_q    <= 1'b0;
          mem_we_q <= 1'b0;
          memwr_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
